modulator_sequencer: RTL

Table-driven controller that sequences the PWM sine modulator through a programmed list of operating points. Each entry holds the two clock-division factors, the frequency select and a dwell time; the block applies the entries in order and holds each for its dwell count. It sits between the AXI register slice, which writes the table and issues start/stop, and the modulator's `sw0`/`div_factor_freqhigh`/`div_factor_freqlow` inputs.

---
 rtl/modulator_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/modulator_sequencer.sv
// Table-driven sequencer that steps the PWM sine modulator through programmed operating points.
// Build option: define MODSEQ_LOOP_EN to wrap back to entry 0 forever instead of finishing.
module modulator_sequencer #(
  parameter int          entries_p      = 4,
  parameter int          dwell_width_p  = 16,
  parameter logic [31:0] def_div_high_p = 32'd1000000,
  parameter logic [31:0] def_div_low_p  = 32'd4000000
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           wr_en,
  input  logic [$clog2(entries_p)-1:0]   wr_addr,
  input  logic [31:0]                    wr_div_high,
  input  logic [31:0]                    wr_div_low,
  input  logic                           wr_sel,
  input  logic [dwell_width_p-1:0]       wr_dwell,
  input  logic [$clog2(entries_p)-1:0]   last_idx,
  input  logic                           start,
  input  logic                           stop,
  output logic                           busy,
  output logic                           done,
  output logic                           step,
  output logic                           wr_err,
  output logic [$clog2(entries_p)-1:0]   cur_idx,
  output logic                           sw0_out,
  output logic [31:0]                    div_factor_freqhigh,
  output logic [31:0]                    div_factor_freqlow,
  output logic [1:0]                     state_dbg
);

  localparam int idx_w_lp = $clog2(entries_p);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]              tbl_high  [entries_p];
  logic [31:0]              tbl_low   [entries_p];
  logic                     tbl_sel   [entries_p];
  logic [dwell_width_p-1:0] tbl_dwell [entries_p];

  logic [dwell_width_p-1:0] cnt_q;
  logic [idx_w_lp-1:0]      last_q;

  logic                     load_en;
  logic                     finish;
  logic [idx_w_lp-1:0]      load_idx;
  logic [dwell_width_p-1:0] load_dwell;
  logic [dwell_width_p-1:0] reload_val;

  assign state_dbg = state_q;

  // start/stop are single-cycle strobes sampled on the clock edge; stop always
  // overrides start, and start only has effect while IDLE.
  always_comb begin
    state_d  = state_q;
    load_en  = 1'b0;
    finish   = 1'b0;
    load_idx = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          load_en = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          if (cur_idx < last_q) begin
            load_en  = 1'b1;
            load_idx = cur_idx + 1'b1;
          end else begin
`ifdef MODSEQ_LOOP_EN
            load_en  = 1'b1;
            load_idx = '0;
`else
            state_d = DONE;
            finish  = 1'b1;
`endif
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (stop) begin
      state_d = IDLE;
      load_en = 1'b0;
      finish  = 1'b0;
    end
    load_dwell = tbl_dwell[load_idx];
    // A zero dwell is stretched to one cycle so the counter can never wrap.
    reload_val = (load_dwell == '0) ? '0 : load_dwell - 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q             <= IDLE;
      cnt_q               <= '0;
      last_q              <= '0;
      cur_idx             <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      step                <= 1'b0;
      wr_err              <= 1'b0;
      sw0_out             <= 1'b0;
      div_factor_freqhigh <= def_div_high_p;
      div_factor_freqlow  <= def_div_low_p;
      for (int i = 0; i < entries_p; i++) begin
        tbl_high[i]  <= def_div_high_p;
        tbl_low[i]   <= def_div_low_p;
        tbl_sel[i]   <= 1'b0;
        tbl_dwell[i] <= dwell_width_p'(1);
      end
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN);
      step    <= load_en;
      done    <= finish;
      wr_err  <= wr_en & busy;
      // Table update lands after this edge, so a same-edge start still sees the old entry.
      if (wr_en && !busy) begin
        tbl_high[wr_addr]  <= wr_div_high;
        tbl_low[wr_addr]   <= wr_div_low;
        tbl_sel[wr_addr]   <= wr_sel;
        tbl_dwell[wr_addr] <= wr_dwell;
      end
      if (load_en) begin
        div_factor_freqhigh <= tbl_high[load_idx];
        div_factor_freqlow  <= tbl_low[load_idx];
        sw0_out             <= tbl_sel[load_idx];
        cur_idx             <= load_idx;
        cnt_q               <= reload_val;
      end else if (state_q == RUN && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (load_en && state_q == IDLE) last_q <= last_idx;
    end
  end

endmodule
